prog_clk_div: RTL
=================

# prog_clk_div

Parametrised programmable clock-enable divider with runtime divisor and high-time control. It generates a divided waveform `dout` plus a one-cycle period-start strobe `tick` from the single system clock. It is the general-purpose successor to the fixed divide-by-3 toggler and covers every divisor from 2 to 2^CNT_W-1 with arbitrary duty. Downstream logic uses `dout` as a level and `tick` as a clock enable. Neither output is ever used as a clock.

## Interface
- `CNT_W`, default 8: width of the counter, divisor and high-time fields.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: run enable; low stops the divider and aborts the current period.
- `div` input CNT_W: period length N in clk cycles; values 0 and 1 are clamped to 2.
- `high_cnt` input CNT_W: number of cycles `dout` is high at the start of each period.
- `sync` input 1: period restart request; this port exists only with `PCD_SYNC_EN`.
- `dout` output 1: divided waveform, registered.
- `tick` output 1: one-cycle pulse in the first cycle of every period, registered.
- `active` output 1: high while the FSM is in RUN.

## Operation
- Registers:
  - `cnt` (CNT_W).
  - Shadow registers `div_q` and `hi_q` (CNT_W each).
  - `state` in {IDLE, RUN}.
  - `dout`, `tick`.
- Reset values: state=IDLE, cnt=0, div_q=2, hi_q=0, dout=0, tick=0, active=0.
- IDLE behaviour:
  - cnt held at 0, dout=0, tick=0.
  - Shadows load clamp(div) and high_cnt every cycle.
- IDLE→RUN: on the first cycle `en`=1 is sampled.
  - cnt<=0, tick<=1.
  - dout<=(hi_q!=0), using the shadow value captured in the previous cycle.
- RUN, en=1, cnt==div_q-1 (period boundary):
  - cnt<=0.
  - div_q<=clamp(div), hi_q<=high_cnt.
  - tick<=1.
  - dout<=(0 < new hi_q).
- RUN, en=1, otherwise:
  - cnt<=cnt+1, tick<=0.
  - dout<=(cnt+1 < hi_q).
- RUN, en=0:
  - Go to IDLE next cycle, with cnt<=0, dout<=0, tick<=0.
  - The partial period is discarded and no tick is emitted.
- Divisor and high-time changes take effect only at a period boundary or in IDLE. There are no glitched or truncated periods.
- Duty rules:
  - high_cnt=0 gives dout constantly 0.
  - high_cnt>=N gives dout constantly 1.
  - `tick` still pulses every N cycles in both cases.
- Arithmetic:
  - All compares are unsigned CNT_W.
  - cnt never exceeds div_q-1, so no wrap-around is possible.
  - Clamp is div<2 → 2.

## Timing
- Latency from `en` rising to the first tick and first dout high: 1 cycle, with both registered on the next edge.
- Period: exactly N=clamp(div) cycles between consecutive ticks.
- `dout` is high for min(H,N) cycles per period, where H=high_cnt, starting in the tick cycle.
- A `div`/`high_cnt` change during RUN takes effect on the next tick. During IDLE it takes effect on the first tick after `en`.
- `reset` overrides `en` and `sync`. A reset mid-period returns all outputs to their reset values on the next edge.
- `en` toggled low-then-high restarts the period from cnt=0, with a tick on the re-entry cycle.

## Configuration
- Macro `PCD_SYNC_EN`.
- Defined:
  - The `sync` port exists.
  - In RUN with en=1, sync=1 is treated exactly like a period boundary: cnt<=0, shadows reload, tick<=1, dout<=(0<new hi_q).
  - sync coinciding with a natural boundary produces a single restart and a single tick.
  - sync in IDLE or with en=0 is ignored.
- Undefined:
  - The port is absent.
  - Periods are set only by the counter.

## Test plan
- Legacy match: reset, then div=3, high_cnt=2, en=1 → dout sequence 1,1,0 repeating, tick on every dout 0→1 cycle, active=1.
- Clamp and extremes:
  - div=0 or div=1 with high_cnt=1 → period 2, dout 1,0.
  - div=5, high_cnt=0 → dout stuck 0, tick every 5 cycles.
  - div=5, high_cnt=9 → dout stuck 1.
- Mid-period reprogram: div=8, high_cnt=4 running; change to div=4, high_cnt=1 at cnt=2 → current period finishes 8 cycles (4 high), then 4-cycle periods with 1 high.
- Abort/reset: en=0 at cnt=3 of div=6 → next cycle dout=0, tick=0, active=0; en=1 again → tick next cycle with cnt=0. Synchronous reset mid-period gives the same abort and all outputs 0.
- Width: CNT_W=4, div=15, high_cnt=7 → period 15, 7 high, with no counter overflow over 3 periods.
- With `PCD_SYNC_EN`, div=10:
  - sync pulse at cnt=4 → tick next cycle, new period of full 10 cycles.
  - sync at cnt=9 → exactly one tick.

Source files
------------

// File: rtl/prog_clk_div.sv
// Programmable clock-enable divider: period-start strobe `tick` plus a duty-controlled level `dout`.
// Optional PCD_SYNC_EN adds a `sync` input that forces an early period restart while running.
module prog_clk_div #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high_cnt,
`ifdef PCD_SYNC_EN
  input  logic             sync,
`endif
  output logic             dout,
  output logic             tick,
  output logic             active
);

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_hi_q;
  logic             r_dout;
  logic             r_tick;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic             w_dout_nxt;
  logic             w_tick_nxt;

  logic [CNT_W-1:0] w_div_clamped;
  logic [CNT_W-1:0] w_div_m1;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_restart;

  assign w_div_clamped = (div < MIN_DIV) ? MIN_DIV : div;
  assign w_div_m1      = r_div_q - CNT_W'(1);
  assign w_cnt_inc     = r_cnt + CNT_W'(1);

  // A sync request coinciding with the natural boundary collapses into one restart.
`ifdef PCD_SYNC_EN
  assign w_restart = (r_cnt == w_div_m1) || sync;
`else
  assign w_restart = (r_cnt == w_div_m1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div_q <= MIN_DIV;
      r_hi_q  <= '0;
      r_dout  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div_q <= w_div_nxt;
      r_hi_q  <= w_hi_nxt;
      r_dout  <= w_dout_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div_q;
    w_hi_nxt    = r_hi_q;
    w_dout_nxt  = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Shadows track the inputs so the first period after en uses fresh settings.
        w_cnt_nxt = '0;
        w_div_nxt = w_div_clamped;
        w_hi_nxt  = high_cnt;
        if (en) begin
          w_state_nxt = S_RUN;
          w_tick_nxt  = 1'b1;
          w_dout_nxt  = (r_hi_q != '0);
        end
      end
      S_RUN: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_restart) begin
          w_cnt_nxt  = '0;
          w_div_nxt  = w_div_clamped;
          w_hi_nxt   = high_cnt;
          w_tick_nxt = 1'b1;
          w_dout_nxt = (high_cnt != '0);
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_dout_nxt = (w_cnt_inc < r_hi_q);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dout   = r_dout;
  assign tick   = r_tick;
  assign active = (r_state == S_RUN);

endmodule
